// File: rtl/l1_cache_pkg.sv
// Shared types and constants for the L1 line-age scrub sequencer.
package l1_cache_pkg;

    localparam int AGE_W       = 4;
    localparam int LINE_INDEX_W = 16;
    localparam int LINE_WAY_W   = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CHK   = 3'd2,
        EVICT = 3'd3,
        DONE  = 3'd4
    } scrub_state_e;

    // Wide enough for any supported geometry; users slice to their own widths.
    typedef struct packed {
        logic [LINE_INDEX_W-1:0] index;
        logic [LINE_WAY_W-1:0]   way;
    } line_addr_t;

endpackage

// File: rtl/stale_tick_gen.sv
// Age-tick prescaler: one-cycle tick every tick_period clocks while enabled.
module stale_tick_gen #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic [PRESC_W-1:0] tick_period_i,
    output logic               tick_o
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] per_q;
    logic [PRESC_W-1:0] limit;
    logic               tick_q;

    // The period is resampled at the start of every count window, so a new value lands at the next wrap.
    always_comb begin
        limit = (cnt_q == '0) ? tick_period_i : per_q;
    end

    // Prescaler count, latched period and registered tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            per_q  <= '0;
            tick_q <= 1'b0;
        end else if (!enable_i || tick_period_i == '0) begin
            cnt_q  <= '0;
            per_q  <= tick_period_i;
            tick_q <= 1'b0;
        end else begin
            per_q <= limit;
            if (cnt_q == limit - 1'b1) begin
                cnt_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 1'b1;
                tick_q <= 1'b0;
            end
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/stale_scrub_ctrl.sv
// Scrub sequencer: on a stale event walks every set/way and requests eviction of stale valid lines.
module stale_scrub_ctrl
    import l1_cache_pkg::*;
#(
    parameter int NUM_SETS   = 64,
    parameter int NUM_WAYS   = 4,
    parameter int INDEX_BITS = $clog2(NUM_SETS),
    parameter int WAY_BITS   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    parameter int PRESC_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PRESC_W-1:0]    tick_period,
    input  logic [AGE_W-1:0]      threshold,
    output logic                  tick_en,
    input  logic                  stale_event,
    input  logic                  cpu_busy,
    output logic                  rd_en,
    output logic [INDEX_BITS-1:0] rd_index,
    output logic [WAY_BITS-1:0]   rd_way,
    input  logic [AGE_W-1:0]      rd_age,
    input  logic                  rd_valid,
    input  logic                  rd_dirty,
    output logic                  evict_valid,
    input  logic                  evict_ready,
    output logic [INDEX_BITS-1:0] evict_index,
    output logic [WAY_BITS-1:0]   evict_way,
    output logic                  evict_dirty,
    output logic                  busy,
    output logic [15:0]           evict_cnt
);

    scrub_state_e state_q, state_d;
    line_addr_t   cur_q, cur_d, cur_next;
    logic         pend_q;
    logic         dirty_q, dirty_d;
    logic [15:0]  ecnt_q;
    logic         start, abort, last_line, stale, accept;

    stale_tick_gen #(.PRESC_W(PRESC_W)) u_tick (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .tick_period_i(tick_period),
        .tick_o       (tick_en)
    );

    // Cursor bookkeeping and line classification.
    always_comb begin
        last_line = (cur_q.index == LINE_INDEX_W'(NUM_SETS - 1)) &&
                    (cur_q.way == LINE_WAY_W'(NUM_WAYS - 1));
        cur_next = cur_q;
        if (cur_q.way == LINE_WAY_W'(NUM_WAYS - 1)) begin
            cur_next.way   = '0;
            cur_next.index = cur_q.index + 1'b1;
        end else begin
            cur_next.way = cur_q.way + 1'b1;
        end
        stale  = rd_valid && (threshold != '0) && (rd_age >= threshold);
        accept = (state_q == EVICT) && evict_ready;
    end

    // Next-state and read-strobe logic of the scan FSM.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dirty_d = dirty_q;
        start   = 1'b0;
        abort   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q && enable) begin
                    state_d = RD;
                    cur_d   = '0;
                    start   = 1'b1;
                end
            end
            RD: begin
                if (!enable) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (!cpu_busy) begin
                    rd_en   = 1'b1;
                    state_d = CHK;
                end
            end
            CHK: begin
                if (!enable) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end else if (stale) begin
                    state_d = EVICT;
                    dirty_d = rd_dirty;
                end else if (last_line) begin
                    state_d = DONE;
                end else begin
                    cur_d   = cur_next;
                    state_d = RD;
                end
            end
            EVICT: begin
                if (evict_ready) begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (last_line) begin
                        state_d = DONE;
                    end else begin
                        cur_d   = cur_next;
                        state_d = RD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, cursor and captured dirty bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dirty_q <= dirty_d;
        end
    end

    // Pending flag: a stale event during a scan queues exactly one rescan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else if (stale_event && enable) begin
            pend_q <= 1'b1;
        end else if (start || abort) begin
            pend_q <= 1'b0;
        end
    end

    // Saturating count of accepted evict handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt_q <= '0;
        end else if (accept && ecnt_q != 16'hFFFF) begin
            ecnt_q <= ecnt_q + 16'd1;
        end
    end

    assign rd_index    = cur_q.index[INDEX_BITS-1:0];
    assign rd_way      = cur_q.way[WAY_BITS-1:0];
    assign evict_valid = (state_q == EVICT);
    assign evict_index = cur_q.index[INDEX_BITS-1:0];
    assign evict_way   = cur_q.way[WAY_BITS-1:0];
    assign evict_dirty = dirty_q;
    assign busy        = (state_q != IDLE);
    assign evict_cnt   = ecnt_q;

endmodule
